// File: rtl/timer_capture_32.sv
// timer_capture_32: capture stage beside the 32-bit timer.
// Each capture pin is synchronised, edge-detected, and on a selected edge the
// current timer count is latched into that channel's capture register. Every
// channel has a sticky capture interrupt flag and a sticky overrun flag.
// cap_irq is the registered OR of all capture interrupt flags.
//
// This block has no handshakes. Each input is sampled on every rising clk edge,
// and each output is a plain register that is valid in every cycle.

module timer_capture_32 #(
    parameter int NUM_CH      = 2,
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        cap_in,
    input  logic [WIDTH-1:0]         tc,
    input  logic                     tc_en,
    input  logic [3*NUM_CH-1:0]      ccr,
    input  logic [NUM_CH-1:0]        ir_clr,
    output logic [NUM_CH*WIDTH-1:0]  cr_out,
    output logic [NUM_CH-1:0]        cap_evt,
    output logic [NUM_CH-1:0]        cap_ir,
    output logic [NUM_CH-1:0]        overrun,
    output logic                     cap_irq
);

    // Per-channel synchroniser chain. Bit 0 is the first flop, and the top bit is the
    // synchronised pin value.
    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [NUM_CH-1:0]      sync_s;
    logic [NUM_CH-1:0]      hist_q;
    logic [WIDTH-1:0]       cr_q [NUM_CH];

    logic [NUM_CH-1:0]      rise;
    logic [NUM_CH-1:0]      fall;
    logic [NUM_CH-1:0]      cap;
    logic [NUM_CH-1:0]      set_ir;
    logic [NUM_CH-1:0]      ovr_set;
    logic [NUM_CH-1:0]      cap_ir_nxt;
    logic [NUM_CH-1:0]      overrun_nxt;

    // Shift each asynchronous pin through its synchroniser chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NUM_CH; n++) begin
                sync_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                sync_q[n] <= {sync_q[n][SYNC_STAGES-2:0], cap_in[n]};
            end
        end
    end

    // Pick the synchronised pin value off the end of each chain
    always_comb begin
        sync_s = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            sync_s[n] = sync_q[n][SYNC_STAGES-1];
        end
    end

    // Edge detection, capture qualification and next flag values.
    // A set beats a same-cycle clear. Overrun is counted only while the timer runs.
    always_comb begin
        rise        = sync_s & ~hist_q;
        fall        = ~sync_s & hist_q;
        cap         = '0;
        set_ir      = '0;
        ovr_set     = '0;
        cap_ir_nxt  = '0;
        overrun_nxt = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            cap[n]         = (rise[n] & ccr[3*n]) | (fall[n] & ccr[3*n+1]);
            set_ir[n]      = cap[n] & ccr[3*n+2];
            ovr_set[n]     = set_ir[n] & cap_ir[n] & ~ir_clr[n] & tc_en;
            cap_ir_nxt[n]  = set_ir[n] | (cap_ir[n] & ~ir_clr[n]);
            overrun_nxt[n] = ovr_set[n] | (overrun[n] & ~ir_clr[n]);
        end
    end

    // Edge history, capture registers, event pulse and sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q  <= '0;
            cap_evt <= '0;
            cap_ir  <= '0;
            overrun <= '0;
            cap_irq <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                cr_q[n] <= '0;
            end
        end else begin
            hist_q  <= sync_s;
            cap_evt <= cap;
            cap_ir  <= cap_ir_nxt;
            overrun <= overrun_nxt;
            cap_irq <= |cap_ir_nxt;
            for (int n = 0; n < NUM_CH; n++) begin
                // The newest capture always wins, including on overrun
                if (cap[n]) begin
                    cr_q[n] <= tc;
                end
            end
        end
    end

    // Flatten the capture registers onto the output bus
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_cr
            assign cr_out[g*WIDTH +: WIDTH] = cr_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_timer_capture_32.sv
// tb_timer_capture_32: bench for timer_capture_32.
// The behavioural model keeps a packed history of the sampled pin values for each
// channel. The synchronised edge seen at clock edge t is the pin value sampled
// SYNC_STAGES edges earlier, compared with the value sampled one edge before that.
module tb_timer_capture_32;
  localparam int NUM_CH      = 2;
  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_CH-1:0]       cap_in = '0;
  logic [WIDTH-1:0]        tc = '0;
  logic                    tc_en = 1'b1;
  logic [3*NUM_CH-1:0]     ccr = '0;
  logic [NUM_CH-1:0]       ir_clr = '0;
  logic [NUM_CH*WIDTH-1:0] cr_out;
  logic [NUM_CH-1:0]       cap_evt;
  logic [NUM_CH-1:0]       cap_ir;
  logic [NUM_CH-1:0]       overrun;
  logic                    cap_irq;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;
  logic [WIDTH-1:0] tc_inc = '0;

  timer_capture_32 #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .cap_in(cap_in), .tc(tc), .tc_en(tc_en), .ccr(ccr),
    .ir_clr(ir_clr), .cr_out(cr_out), .cap_evt(cap_evt), .cap_ir(cap_ir),
    .overrun(overrun), .cap_irq(cap_irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0]       m_hist [NUM_CH];
  logic [WIDTH-1:0]  m_cr [NUM_CH];
  logic [NUM_CH-1:0] m_evt = '0;
  logic [NUM_CH-1:0] m_ir = '0;
  logic [NUM_CH-1:0] m_ovr = '0;
  logic              m_irq = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NUM_CH; n++) begin
        m_hist[n] = '0;
        m_cr[n] = '0;
      end
      m_evt = '0; m_ir = '0; m_ovr = '0; m_irq = 1'b0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        bit now_v, old_v, hit, intr, ovr_hit;
        m_hist[n] = {m_hist[n][14:0], cap_in[n]};
        now_v = m_hist[n][SYNC_STAGES];
        old_v = m_hist[n][SYNC_STAGES+1];
        hit = (now_v && !old_v && ccr[3*n]) || (!now_v && old_v && ccr[3*n+1]);
        intr = hit && ccr[3*n+2];
        ovr_hit = intr && m_ir[n] && !ir_clr[n] && tc_en;
        m_evt[n] = hit;
        if (hit) m_cr[n] = tc;
        m_ovr[n] = ovr_hit ? 1'b1 : (ir_clr[n] ? 1'b0 : m_ovr[n]);
        m_ir[n]  = intr ? 1'b1 : (ir_clr[n] ? 1'b0 : m_ir[n]);
      end
      m_irq = |m_ir;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // compare every cycle, 2 time units after the active edge
  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      for (int n = 0; n < NUM_CH; n++) begin
        check($sformatf("model_cr%0d", n), cr_out[n*WIDTH +: WIDTH], m_cr[n]);
        check($sformatf("model_evt%0d", n), cap_evt[n], m_evt[n]);
        check($sformatf("model_ir%0d", n), cap_ir[n], m_ir[n]);
        check($sformatf("model_ovr%0d", n), overrun[n], m_ovr[n]);
      end
      check("model_irq", cap_irq, m_irq);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      tc = tc + tc_inc;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int ch, input logic [WIDTH-1:0] val);
    @(negedge clk);
    tc = val;
    cap_in[ch] = 1'b1;
    step(4);
    @(negedge clk);
    cap_in[ch] = 1'b0;
    step(3);
  endtask

  task automatic clear_all();
    @(negedge clk);
    ir_clr = '1;
    @(negedge clk);
    ir_clr = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    reset = 1'b0;
    chk_on = 1;

    // 1: reset holds everything at 0 while pins and tc toggle
    repeat (4) begin
      @(negedge clk);
      cap_in = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      tc = $urandom;
      ccr = '1;
    end
    after_edge();
    check("rst_cr", cr_out, '0);
    check("rst_flags", {cap_evt, cap_ir, overrun, cap_irq}, '0);
    @(negedge clk);
    cap_in = '0;
    ccr = '0;
    reset = 1'b1;
    step(6);
    check("rel_evt_ir", {cap_evt, cap_ir}, '0);

    // 2: latency, channel 0 rise with interrupt enabled
    @(negedge clk);
    ccr[2:0] = 3'b101;
    tc = 100;
    tc_inc = 1;
    cap_in[0] = 1'b1;
    step(2);
    after_edge();
    check("lat_cr0", cr_out[WIDTH-1:0], 102);
    check("lat_evt0", cap_evt[0], 1);
    check("lat_ir0", cap_ir[0], 1);
    check("lat_irq", cap_irq, 1);
    after_edge();
    check("lat_evt0_gone", cap_evt[0], 0);
    @(negedge clk);
    cap_in[0] = 1'b0;
    tc_inc = 0;
    step(4);
    clear_all();

    // 3: edge select on channel 1
    @(negedge clk);
    ccr[5:3] = 3'b010;
    tc = 400;
    cap_in[1] = 1'b1;
    step(4);
    check("sel_rise_ignored", cr_out[2*WIDTH-1:WIDTH], 0);
    @(negedge clk);
    tc = 555;
    cap_in[1] = 1'b0;
    step(4);
    check("sel_fall_cr1", cr_out[2*WIDTH-1:WIDTH], 555);
    check("sel_no_int", cap_ir[1], 0);
    @(negedge clk);
    ccr[5:3] = 3'b011;
    tc = 600;
    cap_in[1] = 1'b1;
    step(4);
    check("both_rise_cr1", cr_out[2*WIDTH-1:WIDTH], 600);
    @(negedge clk);
    tc = 650;
    cap_in[1] = 1'b0;
    step(4);
    check("both_fall_cr1", cr_out[2*WIDTH-1:WIDTH], 650);
    @(negedge clk);
    ccr[5:3] = 3'b000;
    tc = 900;
    cap_in[1] = 1'b1;
    step(4);
    @(negedge clk);
    cap_in[1] = 1'b0;
    step(4);
    check("none_cr1", cr_out[2*WIDTH-1:WIDTH], 650);

    // 4: overrun only while the timer runs
    tc_en = 1'b1;
    pulse(0, 700);
    pulse(0, 800);
    check("ovr_set", overrun[0], 1);
    check("ovr_cr0_newest", cr_out[WIDTH-1:0], 800);
    clear_all();
    check("ovr_cleared", {cap_ir[0], overrun[0]}, 0);
    tc_en = 1'b0;
    pulse(0, 710);
    pulse(0, 810);
    check("ovr_frozen", overrun[0], 0);
    check("ovr_frozen_cr0", cr_out[WIDTH-1:0], 810);
    check("ovr_frozen_ir", cap_ir[0], 1);

    // 5: set beats clear, then clear alone
    tc_en = 1'b1;
    clear_all();
    pulse(0, 1000);
    @(negedge clk);
    tc = 1100;
    cap_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ir_clr[0] = 1'b1;
    after_edge();
    check("clash_ir", cap_ir[0], 1);
    check("clash_ovr", overrun[0], 0);
    check("clash_cr0", cr_out[WIDTH-1:0], 1100);
    @(negedge clk);
    ir_clr[0] = 1'b0;
    cap_in[0] = 1'b0;
    step(3);
    pulse(0, 1200);
    check("clash_ovr_again", overrun[0], 1);
    clear_all();
    check("clr_alone", {cap_ir[0], overrun[0], cap_irq}, 0);

    // 6: async reset between pin edge and capture register load
    @(negedge clk);
    tc = 2000;
    cap_in[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cap_in[0] = 1'b0;
    after_edge();
    check("mid_rst_cr0", cr_out[WIDTH-1:0], 0);
    check("mid_rst_evt", cap_evt, 0);
    @(negedge clk);
    reset = 1'b1;
    step(5);
    check("mid_rst_after_cr0", cr_out[WIDTH-1:0], 0);

    // random phase, checked by the model every cycle
    tc_inc = 1;
    ccr = 6'b101_111;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      for (int n = 0; n < NUM_CH; n++) begin
        if ($urandom_range(0, 3) == 0) cap_in[n] = ~cap_in[n];
      end
      if ($urandom_range(0, 15) == 0) tc = $urandom;
      else tc = tc + tc_inc;
      tc_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) ccr = 6'($urandom_range(0, 63));
      ir_clr = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1)) : '0;
      reset = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    reset = 1'b1;
    ir_clr = '0;
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
